// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with a glitch-free divisor reload.
// A new divisor is held in a one-entry pending register and applied only at a period boundary.
module clk_div_prog #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             div_err,
  output logic [CNT_W-1:0] div_cur,
  output logic             clkout,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;
  logic             div_err_q, div_err_d;
  logic             last;
  logic             xfer;

  assign last = (cnt_q == div_cur_q - CNT_W'(1));
  assign xfer = div_valid && !pend_vld_q;

  always_comb begin
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    clkout_d   = clkout_q;
    tick_d     = 1'b0;
    div_err_d  = 1'b0;

    if (en) begin
      cnt_d    = last ? '0 : cnt_q + CNT_W'(1);
      clkout_d = (cnt_q >= (div_cur_q >> 1));
      tick_d   = last;
      if (last && pend_vld_q) begin
        div_cur_d  = pend_q;
        cnt_d      = '0;
        pend_vld_d = 1'b0;
      end
    end else if (pend_vld_q) begin
      // While stopped there is no boundary to wait for, so restart cleanly at phase 0.
      div_cur_d  = pend_q;
      cnt_d      = '0;
      clkout_d   = 1'b0;
      pend_vld_d = 1'b0;
    end

    // Transfer only happens with pend_vld_q low, so it never collides with the apply above.
    if (xfer) begin
      if (div_in >= CNT_W'(2)) begin
        pend_d     = div_in;
        pend_vld_d = 1'b1;
      end else begin
        div_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      div_cur_q  <= CNT_W'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clkout_q   <= 1'b0;
      tick_q     <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clkout_q   <= clkout_d;
      tick_q     <= tick_d;
      div_err_q  <= div_err_d;
    end
  end

  assign div_ready = !pend_vld_q;
  assign div_err   = div_err_q;
  assign div_cur   = div_cur_q;
  assign clkout    = clkout_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: reload handshake, illegal divisors, enable freeze, reset.
module tb_clk_div_prog;

  logic       clkin = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div_in;
  logic       div_valid;
  logic       div_ready;
  logic       div_err;
  logic [7:0] div_cur;
  logic       clkout;
  logic       tick;

  int checks = 0;
  int errors = 0;

  clk_div_prog #(.CNT_W(8), .DEFAULT_DIV(2)) dut (
    .clkin(clkin), .rst(rst), .en(en), .div_in(div_in), .div_valid(div_valid),
    .div_ready(div_ready), .div_err(div_err), .div_cur(div_cur),
    .clkout(clkout), .tick(tick)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  // Run n edges, checking clkout/tick against hand-written '0'/'1' patterns.
  task automatic run_pat(input string tag, input string cpat, input string tpat);
    for (int i = 0; i < cpat.len(); i++) begin
      step();
      chk({tag, "_clk"}, {31'd0, clkout}, {31'd0, cpat.getc(i) == 8'h31});
      chk({tag, "_tick"}, {31'd0, tick}, {31'd0, tpat.getc(i) == 8'h31});
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; div_in = 8'd0; div_valid = 1'b0;
    #1;
    chk("rst_clkout", {31'd0, clkout}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_err", {31'd0, div_err}, 32'd0);
    chk("rst_divcur", {24'd0, div_cur}, 32'd2);
    #1 rst = 1'b0;
    chk("rst_ready", {31'd0, div_ready}, 32'd1);

    // Default divide-by-2
    run_pat("d2", "010101", "010101");
    chk("d2_divcur", {24'd0, div_cur}, 32'd2);

    // Load 5 while running at D=2 (cnt=0 now)
    div_in = 8'd5; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    chk("l5_ready_low", {31'd0, div_ready}, 32'd0);
    chk("l5_divcur_old", {24'd0, div_cur}, 32'd2);
    step();
    chk("l5_divcur", {24'd0, div_cur}, 32'd5);
    chk("l5_ready_high", {31'd0, div_ready}, 32'd1);
    chk("l5_tick", {31'd0, tick}, 32'd1);
    run_pat("d5", "0011100111", "0000100001");

    // 6 then 3 back to back; 3 stalls until 6 applies
    div_in = 8'd6; div_valid = 1'b1;
    step();
    div_in = 8'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b2b_stall_ready", {31'd0, div_ready}, 32'd0);
      chk("b2b_stall_divcur", {24'd0, div_cur}, 32'd5);
    end
    step();
    chk("b2b_apply6", {24'd0, div_cur}, 32'd6);
    chk("b2b_ready6", {31'd0, div_ready}, 32'd1);
    chk("b2b_tick6", {31'd0, tick}, 32'd1);
    chk("b2b_clk6", {31'd0, clkout}, 32'd1);
    step();
    div_valid = 1'b0;
    chk("b2b_accept3", {31'd0, div_ready}, 32'd0);
    chk("d6_first_clk", {31'd0, clkout}, 32'd0);
    run_pat("d6", "00111", "00001");
    chk("b2b_apply3", {24'd0, div_cur}, 32'd3);
    run_pat("d3", "011011", "001001");

    // Illegal divisors 1 and 0
    div_in = 8'd1; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    chk("err1_pulse", {31'd0, div_err}, 32'd1);
    chk("err1_ready", {31'd0, div_ready}, 32'd1);
    step();
    chk("err1_clear", {31'd0, div_err}, 32'd0);
    div_in = 8'd0; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    chk("err0_pulse", {31'd0, div_err}, 32'd1);
    chk("err0_ready", {31'd0, div_ready}, 32'd1);
    step();
    chk("err0_clear", {31'd0, div_err}, 32'd0);
    chk("err_divcur", {24'd0, div_cur}, 32'd3);
    run_pat("err_per", "11", "01");

    // Switch to D=4, then freeze mid-high phase
    div_in = 8'd4; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    step();
    step();
    chk("d4_divcur", {24'd0, div_cur}, 32'd4);
    run_pat("d4_pre", "001", "000");
    en = 1'b0;
    run_pat("d4_frz", "1111111", "0000000");
    en = 1'b1;
    run_pat("d4_resume", "10011", "10001");

    // Load 8 while disabled: applies immediately on the next edge
    en = 1'b0; div_in = 8'd8; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    chk("dis_pend_ready", {31'd0, div_ready}, 32'd0);
    chk("dis_pend_divcur", {24'd0, div_cur}, 32'd4);
    step();
    chk("dis_apply_divcur", {24'd0, div_cur}, 32'd8);
    chk("dis_apply_clk", {31'd0, clkout}, 32'd0);
    chk("dis_apply_ready", {31'd0, div_ready}, 32'd1);
    en = 1'b1;
    run_pat("d8", "00001", "00000");

    // Reset mid-period with 12 pending
    div_in = 8'd12; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    chk("r12_ready_low", {31'd0, div_ready}, 32'd0);
    chk("r12_clk_high", {31'd0, clkout}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_clkout", {31'd0, clkout}, 32'd0);
    chk("mrst_tick", {31'd0, tick}, 32'd0);
    chk("mrst_divcur", {24'd0, div_cur}, 32'd2);
    #2 rst = 1'b0;
    chk("mrst_ready", {31'd0, div_ready}, 32'd1);
    run_pat("post_rst", "01010101", "01010101");
    chk("post_rst_divcur", {24'd0, div_cur}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider; successor to the fixed divide-by-2 block.
- Generates a registered divided clock `clkout` and a one-cycle period `tick` from `clkin`.
- Divisor is set by a `DEFAULT_DIV` parameter and can be reloaded at run time through a valid/ready handshake. New divisors take effect only at a period boundary, so `clkout` never glitches.
- Sits in the clock/timing utilities layer; feeds slow-strobe consumers (UART baud, LED scan, sampling enables).

Parameters:
- CNT_W, 8, width of the divisor and counter; legal divisors 2..2^CNT_W-1.
- DEFAULT_DIV, 2, active divisor after reset; must be in 2..2^CNT_W-1.

Ports:
- clkin  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable; 0 freezes the counter and outputs.
- div_in  input  CNT_W  requested divisor.
- div_valid  input  1  `div_in` is valid.
- div_ready  output  1  block can accept a divisor; equals NOT `pend_vld`.
- div_err  output  1  one-cycle pulse when an accepted divisor is illegal.
- div_cur  output  CNT_W  divisor currently in effect.
- clkout  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse, once per `clkout` period.

Behaviour:
- Reset (async, `rst`=1):
  - cnt=0, clkout=0, tick=0, div_err=0.
  - div_cur=DEFAULT_DIV; pending register empty, so div_ready=1 once `rst` releases (combinational NOT `pend_vld`).
- Counting, each edge with en=1 (D = div_cur):
  - cnt <= (cnt==D-1) ? 0 : cnt+1.
  - clkout <= (cnt >= D>>1), evaluated on the pre-edge cnt, so clkout lags cnt by one cycle.
  - Result: low for floor(D/2) cycles, high for ceil(D/2) cycles; period exactly D cycles. Odd D gives the extra cycle to the high phase.
  - tick <= (cnt==D-1). tick is high for the one cycle in which cnt==0; otherwise 0.
- Disabled (en=0): cnt, clkout and div_cur hold; tick <= 0. When en returns to 1, counting resumes from the held cnt; no phase reset.
- Handshake:
  - Transfer occurs on an edge where div_valid & div_ready are both 1.
  - Legal `div_in` (>=2): stored in pending register; `pend_vld` <= 1, so div_ready drops the next cycle.
  - Illegal `div_in` (0 or 1): not stored; `pend_vld` stays 0; div_err pulses 1 the next cycle.
  - div_valid with div_ready=0: no transfer. The source must hold `div_in` until it sees ready.
- Apply rule for the pending divisor:
  - If en=1 and cnt==D-1: div_cur <= pending, cnt <= 0, `pend_vld` <= 0, all on the same edge. The period that follows uses the new D.
  - If en=0 and `pend_vld`=1: applied on the next edge; cnt <= 0, clkout <= 0.
- Simultaneous events:
  - A transfer on the same edge as a boundary does not apply at that boundary; it waits for the next boundary.
  - `pend_vld` clears and a new transfer cannot both occur on one edge, because div_ready was 0 that cycle.
- Arithmetic: cnt is CNT_W bits; compare `D>>1` unsigned; no wrap beyond D-1.
- Reset mid-period or mid-handshake:
  - All state returns to reset values immediately; any pending divisor is discarded.
  - clkout may be truncated; this is acceptable.

Test Plan:
- Reset, en=1, DEFAULT_DIV=2 -> clkout toggles every cycle (period 2); tick every 2nd cycle; div_cur=2.
- Load div_in=5 while running at D=2 -> div_ready low until the next boundary. Then clkout low 2 / high 3, period 5; tick every 5 cycles; div_cur=5.
- Load div_in=6, then div_in=3 sent back-to-back -> second request stalls (div_ready=0) until 6 is applied at a boundary. Then 3 is accepted and applied at the end of the first D=6 period; no clkout high/low phase shorter than expected.
- div_in=1 and div_in=0 -> each gives a div_err one-cycle pulse; div_cur and period unchanged; div_ready stays 1.
- en=0 for 7 cycles mid-high-phase at D=4 -> cnt/clkout frozen, tick=0. On re-enable, the remaining high cycles complete, then normal period 4.
- Assert rst mid-period with a pending divisor (D=8 running, 12 pending) -> clkout=0, tick=0 immediately; after release div_cur=DEFAULT_DIV, div_ready=1, and 12 is never applied.
